// File: rtl/fifo1c_pkg.sv
// Shared types and helpers for the commit/discard FIFO.
//   pkt_st_e : state of the packet currently being written
//              (IDLE = nothing pending, PEND = words pending, BAD = pending packet hit overflow)
//   cnt_w()  : width of a word count for a given address width (holds 0..2**aw inclusive)
package fifo1c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    BAD
  } pkt_st_e;

  function automatic int unsigned cnt_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ram1r1w_param.sv
// Simple dual-port RAM, one write port and one registered read port, same clock.
// Read-during-write to the same address returns the old contents. The read register
// resets to zero so the FIFO head output is defined out of reset.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : read address, registered read data
module ram1r1w_param #(
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo1c_cmt.sv
// Single-clock show-ahead FIFO with packet commit/discard on the write side.
// Words are written speculatively at wa_r and only become readable once committed;
// a discard (or an overflow inside the packet followed by commit) rolls wa_r back to
// wa_cmt so a bad frame never reaches the reader.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   data, wrreq                       write word and strobe
//   wr_commit, wr_discard             publish / drop all pending words (incl. this cycle's)
//   rdreq                             pop head word
//   highest_clr                       load watermark with current usedw
//   q                                 head word, valid while empty = 0
//   empty, full, almost_empty, almost_full   status flags
//   usedw                             committed + pending words
//   rd_avail                          words the reader may pop
//   highest_dw                        peak usedw since reset or clear
//   overflow, underflow, pkt_dropped  single-cycle event pulses
module fifo1c_cmt
  import fifo1c_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AFUL_THRES = (2 ** ADDR_WIDTH) - 1,
  parameter int unsigned AEMP_THRES = 1,
  parameter int unsigned PIPE       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic                          wrreq,
  input  logic                          wr_commit,
  input  logic                          wr_discard,
  input  logic                          rdreq,
  input  logic                          highest_clr,
  output logic [DATA_WIDTH-1:0]         q,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [cnt_w(ADDR_WIDTH)-1:0]  usedw,
  output logic [cnt_w(ADDR_WIDTH)-1:0]  rd_avail,
  output logic [cnt_w(ADDR_WIDTH)-1:0]  highest_dw,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          pkt_dropped
);

  localparam int unsigned CntW = cnt_w(ADDR_WIDTH);
  // Commit-to-visible delay line: 2 stages plus the optional output stage.
  localparam int unsigned PubStages = 2 + PIPE;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t DepthCnt = cnt_t'(2 ** ADDR_WIDTH);
  localparam cnt_t AfulLvl  = cnt_t'(AFUL_THRES);
  localparam cnt_t AempLvl  = cnt_t'(AEMP_THRES);

  logic [ADDR_WIDTH-1:0] wa_r, wa_r_d, wa_cmt, wa_cmt_d, ra_r, ra_nxt;
  cnt_t    usedw_q, usedw_d, pend_q, pend_d, vis_q, vis_d, highest_q, highest_d, pub_now;
  cnt_t    pub_q [PubStages];
  pkt_st_e st_q, st_d;
  logic    ovf_q, unf_q, drop_q;

  logic wr_ok, rd_ok, ovf_now, bad_now, drop, publish;
  cnt_t wr_inc, rd_dec;

  always_comb begin
    full    = (usedw_q == DepthCnt);
    empty   = (vis_q == '0);
    wr_ok   = wrreq & ~full;
    rd_ok   = rdreq & ~empty;
    ovf_now = wrreq & full;
    // An overflow this cycle already spoils the packet being committed.
    bad_now = (st_q == BAD) | ovf_now;
    drop    = wr_discard | (wr_commit & bad_now);
    publish = wr_commit & ~drop;
    wr_inc  = cnt_t'(wr_ok);
    rd_dec  = cnt_t'(rd_ok);
    ra_nxt  = ra_r + ADDR_WIDTH'(rd_ok);

    wa_r_d   = wa_r;
    wa_cmt_d = wa_cmt;
    pend_d   = pend_q;
    st_d     = st_q;
    pub_now  = '0;
    usedw_d  = usedw_q - rd_dec;

    if (drop) begin
      // Same-cycle write is dropped along with the rest of the packet.
      wa_r_d  = wa_cmt;
      usedw_d = usedw_q - pend_q - rd_dec;
      pend_d  = '0;
      st_d    = IDLE;
    end else begin
      wa_r_d  = wa_r + ADDR_WIDTH'(wr_ok);
      usedw_d = usedw_q + wr_inc - rd_dec;
      if (publish) begin
        wa_cmt_d = wa_r_d;
        pub_now  = pend_q + wr_inc;
        pend_d   = '0;
        st_d     = IDLE;
      end else begin
        pend_d = pend_q + wr_inc;
        if (ovf_now) begin
          st_d = BAD;
        end else if (wr_ok && (st_q == IDLE)) begin
          st_d = PEND;
        end
      end
    end

    // Commits reach the reader only after the delay line; pops take effect at once so
    // the reader can never pop past the last written word.
    vis_d = vis_q + pub_q[PubStages-1] - rd_dec;

    if (highest_clr) begin
      highest_d = usedw_q;
    end else begin
      highest_d = (usedw_d > highest_q) ? usedw_d : highest_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_r      <= '0;
      wa_cmt    <= '0;
      ra_r      <= '0;
      usedw_q   <= '0;
      pend_q    <= '0;
      vis_q     <= '0;
      highest_q <= '0;
      st_q      <= IDLE;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      drop_q    <= 1'b0;
      for (int i = 0; i < PubStages; i++) begin
        pub_q[i] <= '0;
      end
    end else begin
      wa_r      <= wa_r_d;
      wa_cmt    <= wa_cmt_d;
      ra_r      <= ra_nxt;
      usedw_q   <= usedw_d;
      pend_q    <= pend_d;
      vis_q     <= vis_d;
      highest_q <= highest_d;
      st_q      <= st_d;
      ovf_q     <= ovf_now;
      unf_q     <= rdreq & empty;
      // The requester of a plain discard already knows; only report silent drops.
      drop_q    <= wr_commit & ~wr_discard & bad_now;
      pub_q[0]  <= pub_now;
      for (int i = 1; i < PubStages; i++) begin
        pub_q[i] <= pub_q[i-1];
      end
    end
  end

  // Read port follows ra_nxt so the head word tracks pops without a bubble.
  ram1r1w_param #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wa_r),
    .wdata (data),
    .raddr (ra_nxt),
    .rdata (q)
  );

  assign usedw        = usedw_q;
  assign rd_avail     = vis_q;
  assign highest_dw   = highest_q;
  assign almost_full  = (usedw_q >= AfulLvl);
  assign almost_empty = (vis_q <= AempLvl);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign pkt_dropped  = drop_q;

endmodule

// File: tb/tb_fifo1c_cmt.sv
// Directed and random stimulus against a queue-based model of the commit FIFO.
// Committed words carry the cycle from which the reader may see them; pending words sit
// in a separate queue until commit or discard.
module tb_fifo1c_cmt;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;
  localparam int          LAT   = 3;  // commit edge to first cycle the word is readable

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data;
  logic          wrreq, wr_commit, wr_discard, rdreq, highest_clr;
  logic [DW-1:0] q;
  logic          empty, full, almost_empty, almost_full;
  logic [AW:0]   usedw, rd_avail, highest_dw;
  logic          overflow, underflow, pkt_dropped;

  always #5 clk = ~clk;

  fifo1c_cmt #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .PIPE       (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .wrreq        (wrreq),
    .wr_commit    (wr_commit),
    .wr_discard   (wr_discard),
    .rdreq        (rdreq),
    .highest_clr  (highest_clr),
    .q            (q),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .usedw        (usedw),
    .rd_avail     (rd_avail),
    .highest_dw   (highest_dw),
    .overflow     (overflow),
    .underflow    (underflow),
    .pkt_dropped  (pkt_dropped)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            vis;
  } ent_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  ent_t          cq[$];
  logic [DW-1:0] pq[$];
  bit            bad_m, ovf_m, unf_m, drp_m;
  int            high_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int readable(input int t);
    int n = 0;
    foreach (cq[i]) if (cq[i].vis <= t) n++;
    return n;
  endfunction

  task automatic check_all(input string tag);
    int ra, used;
    ra   = readable(cyc);
    used = cq.size() + pq.size();
    check({tag, ".usedw"}, 32'(usedw), 32'(used));
    check({tag, ".rd_avail"}, 32'(rd_avail), 32'(ra));
    check({tag, ".empty"}, 32'(empty), 32'(ra == 0));
    check({tag, ".full"}, 32'(full), 32'(used == DEPTH));
    check({tag, ".aful"}, 32'(almost_full), 32'(used >= DEPTH - 1));
    check({tag, ".aemp"}, 32'(almost_empty), 32'(ra <= 1));
    check({tag, ".highest"}, 32'(highest_dw), 32'(high_m));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    check({tag, ".underflow"}, 32'(underflow), 32'(unf_m));
    check({tag, ".pkt_dropped"}, 32'(pkt_dropped), 32'(drp_m));
    if (ra > 0) check({tag, ".q"}, 32'(q), 32'(cq[0].d));
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then compare.
  task automatic cycle(input string tag, input bit wr, input logic [DW-1:0] d, input bit cm,
                       input bit ds, input bit rd, input bit clr);
    int   t, ra, used, used_new;
    bit   full_m, empty_m, ovf, bad_now;
    ent_t e;
    t       = cyc;
    ra      = readable(t);
    used    = cq.size() + pq.size();
    full_m  = (used == DEPTH);
    empty_m = (ra == 0);
    data = d; wrreq = wr; wr_commit = cm; wr_discard = ds; rdreq = rd; highest_clr = clr;

    ovf     = wr && full_m;
    ovf_m   = ovf;
    unf_m   = rd && empty_m;
    bad_now = bad_m || ovf;
    drp_m   = cm && !ds && bad_now;
    if (rd && !empty_m) void'(cq.pop_front());
    if (ds || (cm && bad_now)) begin
      pq.delete();
      bad_m = 1'b0;
    end else begin
      if (wr && !full_m) pq.push_back(d);
      if (cm) begin
        foreach (pq[i]) begin
          e.d   = pq[i];
          e.vis = t + 1 + LAT;
          cq.push_back(e);
        end
        pq.delete();
        bad_m = 1'b0;
      end else if (ovf) begin
        bad_m = 1'b1;
      end
    end
    used_new = cq.size() + pq.size();
    if (clr) high_m = used;
    else if (used_new > high_m) high_m = used_new;

    @(posedge clk);
    #1;
    cyc++;
    wrreq = 0; wr_commit = 0; wr_discard = 0; rdreq = 0; highest_clr = 0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (cq.size() > 0); i++) cycle(tag, 0, '0, 0, 0, readable(cyc) > 0, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'd1);
    check({tag, ".aemp"}, 32'(almost_empty), 32'd1);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".aful"}, 32'(almost_full), 32'd0);
    check({tag, ".usedw"}, 32'(usedw), 32'd0);
    check({tag, ".rd_avail"}, 32'(rd_avail), 32'd0);
    check({tag, ".highest"}, 32'(highest_dw), 32'd0);
    check({tag, ".pulses"}, {29'd0, overflow, underflow, pkt_dropped}, 32'd0);
    check({tag, ".q"}, 32'(q), 32'd0);
  endtask

  task automatic model_reset();
    cq.delete(); pq.delete();
    bad_m = 0; ovf_m = 0; unf_m = 0; drp_m = 0; high_m = 0;
  endtask

  initial begin
    rst_n = 1'b0; data = '0; wrreq = 0; wr_commit = 0; wr_discard = 0; rdreq = 0;
    highest_clr = 0;
    model_reset();
    #3;
    check_reset("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Commit visibility: last word carries the commit
    cycle("cv", 1, 16'h0011, 0, 0, 0, 0);
    cycle("cv", 1, 16'h0022, 0, 0, 0, 0);
    cycle("cv", 1, 16'h0033, 1, 0, 0, 0);
    idle("cv", 2);
    check("cv.empty_hold", 32'(empty), 32'd1);
    idle("cv", 1);
    check("cv.head", 32'(q), 32'h11);
    cycle("cv", 0, '0, 0, 0, 1, 0);
    check("cv.pop1", 32'(q), 32'h22);
    cycle("cv", 0, '0, 0, 0, 1, 0);
    check("cv.pop2", 32'(q), 32'h33);
    cycle("cv", 0, '0, 0, 0, 1, 0);
    check("cv.avail0", 32'(rd_avail), 32'd0);

    // Discard, then reuse of the rolled-back addresses
    for (int i = 0; i < 4; i++) cycle("ds", 1, 16'h00D0 + 16'(i), 0, 0, 0, 0);
    check("ds.used4", 32'(usedw), 32'd4);
    cycle("ds", 0, '0, 0, 1, 0, 0);
    check("ds.used0", 32'(usedw), 32'd0);
    cycle("ds", 1, 16'h00A0, 0, 0, 0, 0);
    cycle("ds", 1, 16'h00A1, 1, 0, 0, 0);
    idle("ds", 3);
    check("ds.head", 32'(q), 32'hA0);
    drain("ds");

    // Overflow inside a packet
    for (int i = 0; i < 5; i++) cycle("ov", 1, 16'h0050 + 16'(i), i == 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("ov", 1, 16'h0060 + 16'(i), 0, 0, 0, 0);
    check("ov.pulse", 32'(overflow), 32'd1);
    check("ov.full", 32'(full), 32'd1);
    cycle("ov", 0, '0, 1, 0, 0, 0);
    check("ov.dropped", 32'(pkt_dropped), 32'd1);
    check("ov.used5", 32'(usedw), 32'd5);
    check("ov.avail5", 32'(rd_avail), 32'd5);
    drain("ov");

    // One-word packets with reads whenever data is visible, wrapping the pointers
    for (int i = 0; i < 20; i++) cycle("wrap", 1, 16'h0B00 + 16'(i), 1, 0, readable(cyc) > 0, 0);
    drain("wrap");

    // Underflow and watermark
    cycle("wm", 0, '0, 0, 0, 0, 1);
    cycle("wm", 0, '0, 0, 0, 1, 0);
    check("wm.underflow", 32'(underflow), 32'd1);
    idle("wm", 1);
    for (int i = 0; i < 6; i++) cycle("wm", 1, 16'h0070 + 16'(i), i == 5, 0, 0, 0);
    check("wm.peak6", 32'(highest_dw), 32'd6);
    idle("wm", 3);
    for (int i = 0; i < 4; i++) cycle("wm", 0, '0, 0, 0, 1, 0);
    cycle("wm", 0, '0, 0, 0, 0, 1);
    check("wm.clr2", 32'(highest_dw), 32'd2);
    drain("wm");

    // Reset with committed and pending data in flight
    cycle("mr", 1, 16'h0081, 0, 0, 0, 0);
    cycle("mr", 1, 16'h0082, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("mr", 1, 16'h0090 + 16'(i), 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("mr.rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle("mr", 1, 16'h00C1, 0, 0, 0, 0);
    cycle("mr", 1, 16'h00C2, 1, 0, 0, 0);
    idle("mr", 3);
    check("mr.head", 32'(q), 32'hC1);
    drain("mr");

    // Random traffic
    cycle("rnd", 0, '0, 0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", $urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
    end
    cycle("rnd", 0, '0, 0, 1, 0, 0);
    idle("rnd", 3);
    drain("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
